// File: rtl/firebird7_in_gate2_ijtag_scan_driver_if.sv
// Command/response bus of the IJTAG scan driver.
//   cmd_valid/cmd_ready : request handshake, accepted on posedge when both are 1
//   cmd_len             : number of bits to shift
//   cmd_wdata           : scan-in data, bit 0 shifted first
//   cmd_update          : issue an update cycle after the shift
//   cmd_netrst          : network-reset command (other fields ignored)
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : captured scan-out data, held until the next completion
interface firebird7_in_gate2_ijtag_scan_driver_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_update;
  logic              cmd_netrst;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_len, cmd_wdata, cmd_update, cmd_netrst,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_wdata, cmd_update, cmd_netrst,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/firebird7_in_gate2_ijtag_scan_driver.sv
// IJTAG scan driver: turns a command (shift length, scan-in data, optional update, or a
// network reset) into capture/shift/update control sequences on an IJTAG network and
// returns the scan-out data.
//   ijtag_tck       : sole clock, all state changes on posedge
//   ijtag_reset     : synchronous active-high reset
//   bus             : command/response bus (slave side)
//   ijtag_sel/ce/se/ue/si : registered network controls and scan-in
//   ijtag_to_reset  : registered active-low network reset to downstream SIBs/TDRs
//   ijtag_so        : scan-out from the network
module firebird7_in_gate2_ijtag_scan_driver #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate2_ijtag_scan_driver_if.slave bus,
  output logic ijtag_sel,
  output logic ijtag_ce,
  output logic ijtag_se,
  output logic ijtag_ue,
  output logic ijtag_si,
  output logic ijtag_to_reset,
  input  logic ijtag_so
);

  localparam int unsigned    IdxW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DATA_W);

  typedef enum logic [2:0] {
    StIdle, StNetrst, StCapture, StShift, StUpdate, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              upd_q, upd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  // Output registers, loaded from the next-state decode so every output is a flop.
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel_q, sel_d, ce_q, ce_d, se_q, se_d, ue_q, ue_d, si_q, si_d;
  logic              torst_q, torst_d;

  logic              accept;
  logic [IdxW-1:0]   idx;

  assign accept = bus.cmd_valid & ready_q;
  assign idx    = cnt_q[IdxW-1:0];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    wd_d    = wd_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          cap_d = '0;
          if (bus.cmd_netrst) begin
            state_d = StNetrst;
          end else begin
            len_d   = (bus.cmd_len > MaxLen) ? MaxLen : bus.cmd_len;
            upd_d   = bus.cmd_update;
            wd_d    = bus.cmd_wdata;
            state_d = StCapture;
          end
        end
      end
      StNetrst: begin
        // Network reset is held for two cycles, counted in cnt_q.
        if (cnt_q == LEN_W'(1)) state_d = StDone;
        else                    cnt_d   = cnt_q + LEN_W'(1);
      end
      StCapture: begin
        if (len_q != '0)  state_d = StShift;
        else if (upd_q)   state_d = StUpdate;
        else              state_d = StDone;
      end
      StShift: begin
        cap_d[idx] = ijtag_so;
        wd_d       = wd_q >> 1;
        cnt_d      = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) state_d = upd_q ? StUpdate : StDone;
      end
      StUpdate: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d  = (state_d == StIdle);
    rvalid_d = (state_d == StDone);
    ce_d     = (state_d == StCapture);
    se_d     = (state_d == StShift);
    ue_d     = (state_d == StUpdate);
    sel_d    = ce_d | se_d | ue_d;
    torst_d  = (state_d != StNetrst);
    // wd_q holds wdata >> k during shift cycle k, so the next bit is wd_q[1] mid-shift
    // and wd_q[0] when entering shift from capture.
    si_d     = 1'b0;
    if (state_d == StShift) si_d = (state_q == StShift) ? wd_q[1] : wd_q[0];
    // cap_d already includes the bit sampled at the edge that enters DONE.
    rdata_d  = (state_d == StDone) ? cap_d : rdata_q;
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
      wd_q     <= '0;
      cap_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      sel_q    <= 1'b0;
      ce_q     <= 1'b0;
      se_q     <= 1'b0;
      ue_q     <= 1'b0;
      si_q     <= 1'b0;
      torst_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      wd_q     <= wd_d;
      cap_q    <= cap_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      sel_q    <= sel_d;
      ce_q     <= ce_d;
      se_q     <= se_d;
      ue_q     <= ue_d;
      si_q     <= si_d;
      torst_q  <= torst_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.rsp_valid  = rvalid_q;
  assign bus.rsp_rdata  = rdata_q;
  assign ijtag_sel      = sel_q;
  assign ijtag_ce       = ce_q;
  assign ijtag_se       = se_q;
  assign ijtag_ue       = ue_q;
  assign ijtag_si       = si_q;
  assign ijtag_to_reset = torst_q;

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_scan_driver.sv
module tb_firebird7_in_gate2_ijtag_scan_driver;

  logic ijtag_tck = 1'b0;
  logic ijtag_reset;
  logic ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_to_reset, ijtag_so;

  firebird7_in_gate2_ijtag_scan_driver_if #(.DATA_W(32), .LEN_W(6)) bus ();

  firebird7_in_gate2_ijtag_scan_driver #(.DATA_W(32), .LEN_W(6)) dut (
    .ijtag_tck      (ijtag_tck),
    .ijtag_reset    (ijtag_reset),
    .bus            (bus),
    .ijtag_sel      (ijtag_sel),
    .ijtag_ce       (ijtag_ce),
    .ijtag_se       (ijtag_se),
    .ijtag_ue       (ijtag_ue),
    .ijtag_si       (ijtag_si),
    .ijtag_to_reset (ijtag_to_reset),
    .ijtag_so       (ijtag_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // Loopback network: 32-bit shift register, shifted while SE is high.
  logic [31:0] lb;
  logic [31:0] lb_preload;
  logic        lb_load;
  assign ijtag_so = lb[0];
  always @(posedge ijtag_tck) begin
    if (lb_load)       lb <= lb_preload;
    else if (ijtag_se) lb <= {ijtag_si, lb[31:1]};
  end

  typedef struct {
    logic        netrst;
    logic [5:0]  len;
    logic [31:0] wdata;
    logic        upd;
    logic [31:0] preload;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_ce;
    int          exp_se;
    int          exp_ue;
    int          exp_rstlow;
    logic [31:0] exp_si;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Every sampled cycle also checks control exclusivity and SEL consistency.
  task automatic sample();
    logic ok;
    @(negedge ijtag_tck);
    ok = ($countones({ijtag_ce, ijtag_se, ijtag_ue}) <= 1) &&
         (ijtag_sel == (ijtag_ce | ijtag_se | ijtag_ue));
    chk("ctl_excl", 32'(ok), 32'd1);
  endtask

  task automatic run_vec(input int i);
    int          ce_n, se_n, ue_n, rl_n, lat;
    logic [31:0] si_v, rd;
    bit          got;
    ce_n = 0; se_n = 0; ue_n = 0; rl_n = 0; lat = 0; si_v = '0; rd = '0; got = 0;
    sample();
    chk($sformatf("v%0d_ready_before", i), 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_netrst = vecs[i].netrst;
    bus.cmd_len    = vecs[i].len;
    bus.cmd_wdata  = vecs[i].wdata;
    bus.cmd_update = vecs[i].upd;
    lb_preload     = vecs[i].preload;
    lb_load        = 1'b1;
    @(posedge ijtag_tck);
    #1;
    bus.cmd_valid  = 1'b0;
    lb_load        = 1'b0;
    bus.cmd_wdata  = ~vecs[i].wdata;
    bus.cmd_len    = 6'd63;
    bus.cmd_update = ~vecs[i].upd;
    bus.cmd_netrst = ~vecs[i].netrst;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      sample();
      if (ijtag_ce) ce_n++;
      if (ijtag_ue) ue_n++;
      if (!ijtag_to_reset) rl_n++;
      if (ijtag_se) begin
        if (se_n < 32) si_v[se_n] = ijtag_si;
        se_n++;
      end
      if (bus.rsp_valid) begin
        lat = cyc;
        rd  = bus.rsp_rdata;
        got = 1;
        break;
      end
    end
    chk($sformatf("v%0d_completed", i), 32'(got), 32'd1);
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
    chk($sformatf("v%0d_ce_cycles", i), 32'(ce_n), 32'(vecs[i].exp_ce));
    chk($sformatf("v%0d_se_cycles", i), 32'(se_n), 32'(vecs[i].exp_se));
    chk($sformatf("v%0d_ue_cycles", i), 32'(ue_n), 32'(vecs[i].exp_ue));
    chk($sformatf("v%0d_torst_low", i), 32'(rl_n), 32'(vecs[i].exp_rstlow));
    chk($sformatf("v%0d_si_seq", i), si_v, vecs[i].exp_si);
    sample();
    chk($sformatf("v%0d_ready_after", i), 32'(bus.cmd_ready), 32'd1);
    chk($sformatf("v%0d_rvalid_pulse", i), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("v%0d_rdata_held", i), bus.rsp_rdata, vecs[i].exp_rdata);
  endtask

  initial begin
    int pulses, accepts, rv_n;
    int pcyc[4];

    //           netrst len    wdata         upd   preload       rdata        lat ce se ue rl si
    vecs[0] = '{1'b0, 6'd8,  32'h0000_00A5, 1'b1, 32'h0000_003C, 32'h0000_003C, 11, 1, 8,  1, 0, 32'h0000_00A5};
    vecs[1] = '{1'b1, 6'd8,  32'h0000_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 3,  0, 0,  0, 2, 32'h0000_0000};
    vecs[2] = '{1'b0, 6'd0,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 3,  1, 0,  1, 0, 32'h0000_0000};
    vecs[3] = '{1'b0, 6'd40, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 32'h1234_5678, 34, 1, 32, 0, 0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 6'd5,  32'h0000_01F3, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F, 7,  1, 5,  0, 0, 32'h0000_0013};
    vecs[5] = '{1'b0, 6'd32, 32'h0F0F_0F0F, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 35, 1, 32, 1, 0, 32'h0F0F_0F0F};
    vecs[6] = '{1'b0, 6'd0,  32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 2,  1, 0,  0, 0, 32'h0000_0000};
    vecs[7] = '{1'b0, 6'd1,  32'h0000_0003, 1'b1, 32'h0000_0005, 32'h0000_0001, 4,  1, 1,  1, 0, 32'h0000_0001};

    ijtag_reset    = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.cmd_wdata  = '0;
    bus.cmd_update = 1'b0;
    bus.cmd_netrst = 1'b0;
    lb_preload     = '0;
    lb_load        = 1'b1;

    // Reset values while reset is asserted.
    repeat (3) @(posedge ijtag_tck);
    sample();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_ctl", 32'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}), 32'd0);
    chk("rst_torst", 32'(ijtag_to_reset), 32'd0);
    ijtag_reset = 1'b0;
    lb_load     = 1'b0;
    sample();
    chk("post_rst_torst", 32'(ijtag_to_reset), 32'd1);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset asserted during shift cycle 3 of a len=16 command.
    sample();
    bus.cmd_valid  = 1'b1;
    bus.cmd_netrst = 1'b0;
    bus.cmd_len    = 6'd16;
    bus.cmd_wdata  = 32'h0000_FFFF;
    bus.cmd_update = 1'b1;
    @(posedge ijtag_tck);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (5) sample();
    chk("midrst_in_shift", 32'(ijtag_se), 32'd1);
    ijtag_reset = 1'b1;
    sample();
    chk("midrst_ctl", 32'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}), 32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midrst_rvalid", 32'(bus.rsp_valid), 32'd0);
    ijtag_reset = 1'b0;
    rv_n = 0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (bus.rsp_valid) rv_n++;
    end
    chk("midrst_no_rsp", 32'(rv_n), 32'd0);
    run_vec(0);

    // Back-to-back len=2 commands with cmd_valid held high throughout.
    sample();
    bus.cmd_valid  = 1'b1;
    bus.cmd_netrst = 1'b0;
    bus.cmd_len    = 6'd2;
    bus.cmd_wdata  = 32'h0000_0002;
    bus.cmd_update = 1'b0;
    pulses  = 0;
    accepts = 0;
    for (int k = 0; k < 4; k++) pcyc[k] = 0;
    for (int c = 1; c <= 60 && pulses < 4; c++) begin
      sample();
      if (bus.cmd_ready) accepts++;
      if (bus.rsp_valid) begin
        pcyc[pulses] = c;
        pulses++;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_ready_cycles", 32'(accepts), 32'd3);
    for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap%0d", k), 32'(pcyc[k] - pcyc[k-1]), 32'd5);
    repeat (4) sample();
    chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
